// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding and
// byte-lane select constants for the 16-bit big-endian data memory.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    WR0  = 3'd2,
    RD1  = 3'd3,
    WR1  = 3'd4,
    DONE = 3'd5
  } lsu_state_e;

  // Lane mask bits: bit 1 = high byte [15:8] (even address),
  // bit 0 = low byte [7:0] (odd address).
  localparam int         LANE_HI_BIT = 1;
  localparam int         LANE_LO_BIT = 0;
  localparam logic [1:0] LANE_NONE   = 2'b00;
  localparam logic [1:0] LANE_LO     = 2'b01;
  localparam logic [1:0] LANE_HI     = 2'b10;
  localparam logic [1:0] LANE_BOTH   = 2'b11;

  // Big-endian lane of a single byte given the byte-address LSB.
  function automatic logic [1:0] byte_lane(input logic addr_lsb);
    return addr_lsb ? LANE_LO : LANE_HI;
  endfunction

endpackage

// File: rtl/lsu_byte_merge.sv
// Combinational byte merge for read-modify-write: lanes selected by the
// mask come from the new word, the rest keep the old word's bytes.
module lsu_byte_merge
  import lsu_pkg::*;
(
  input  logic [15:0] old_word_i,
  input  logic [15:0] new_word_i,
  input  logic [1:0]  lane_mask_i,
  output logic [15:0] merged_o
);

  // Per-lane select between old and new byte.
  always_comb begin
    merged_o[15:8] = lane_mask_i[LANE_HI_BIT] ? new_word_i[15:8] : old_word_i[15:8];
    merged_o[7:0]  = lane_mask_i[LANE_LO_BIT] ? new_word_i[7:0]  : old_word_i[7:0];
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller for a 16-bit big-endian byte-addressed memory.
// Handles word/byte loads and stores, splitting unaligned word accesses
// into two memory words (second word address wraps). Byte and unaligned
// stores use read-modify-write through lsu_byte_merge.
// Optional build macro LSU_MISALIGN_TRAP_EN: unaligned word accesses do no
// memory cycles and complete immediately with rsp_err=1.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, and all request
// fields are latched at that edge. rsp_valid is a single-cycle pulse in DONE.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic                  req_byte,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [15:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic [2:0]            dbg_state_o
);

  lsu_state_e            state_q, state_d;
  logic                  wr_q, byte_q, unal_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_q, word_q, result_q;
  logic                  accept, req_unal;
  logic [ADDR_WIDTH-2:0] word_idx_nxt;
  logic [ADDR_WIDTH-1:0] word_a, word_b;
  logic [15:0]           merge_new, merged_word;
  logic [1:0]            merge_mask;

  assign req_ready    = (state_q == IDLE);
  assign accept       = req_valid & req_ready;
  assign req_unal     = ~req_byte & req_addr[0];
  assign word_idx_nxt = addr_q[ADDR_WIDTH-1:1] + {{(ADDR_WIDTH-2){1'b0}}, 1'b1};
  assign word_a       = {addr_q[ADDR_WIDTH-1:1], 1'b0};
  assign word_b       = {word_idx_nxt, 1'b0};
  assign rsp_valid    = (state_q == DONE);
  assign rsp_rdata    = rsp_valid ? result_q : 16'h0000;
  assign mem_wdata    = mem_wr ? merged_word : 16'h0000;
  assign dbg_state_o  = state_q;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;
  assign rsp_err = rsp_valid & err_q;

  // Remember whether the accepted request was an unaligned word access.
  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= req_unal;
  end
`else
  assign rsp_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch request fields at acceptance and capture read data in RD states.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= 1'b0;
      byte_q   <= 1'b0;
      unal_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 16'h0000;
      word_q   <= 16'h0000;
      result_q <= 16'h0000;
    end else begin
      if (accept) begin
        wr_q     <= req_wr;
        byte_q   <= req_byte;
        unal_q   <= req_unal;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        result_q <= 16'h0000;
      end
      if (state_q == RD0) begin
        word_q <= mem_rdata;
        if (!wr_q) begin
          if (byte_q)      result_q <= {8'h00, addr_q[0] ? mem_rdata[7:0] : mem_rdata[15:8]};
          else if (unal_q) result_q <= {mem_rdata[7:0], 8'h00};
          else             result_q <= mem_rdata;
        end
      end
      if (state_q == RD1) begin
        word_q <= mem_rdata;
        if (!wr_q) result_q[7:0] <= mem_rdata[15:8];
      end
    end
  end

  // Next-state and memory-port control.
  always_comb begin
    state_d    = state_q;
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    merge_new  = 16'h0000;
    merge_mask = LANE_NONE;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_wr && !req_byte && !req_addr[0]) state_d = WR0;
          else                                    state_d = RD0;
`ifdef LSU_MISALIGN_TRAP_EN
          if (req_unal) state_d = DONE;
`endif
        end
      end
      RD0: begin
        mem_enable = 1'b1;
        mem_addr   = word_a;
        if (wr_q)        state_d = WR0;
        else if (unal_q) state_d = RD1;
        else             state_d = DONE;
      end
      WR0: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = word_a;
        if (byte_q) begin
          merge_new  = {wdata_q[7:0], wdata_q[7:0]};
          merge_mask = byte_lane(addr_q[0]);
        end else if (unal_q) begin
          merge_new  = {wdata_q[15:8], wdata_q[15:8]};
          merge_mask = LANE_LO;
        end else begin
          merge_new  = wdata_q;
          merge_mask = LANE_BOTH;
        end
        state_d = unal_q ? RD1 : DONE;
      end
      RD1: begin
        mem_enable = 1'b1;
        mem_addr   = word_b;
        state_d    = wr_q ? WR1 : DONE;
      end
      WR1: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = word_b;
        merge_new  = {wdata_q[7:0], wdata_q[7:0]};
        merge_mask = LANE_HI;
        state_d    = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  lsu_byte_merge u_merge (
    .old_word_i  (word_q),
    .new_word_i  (merge_new),
    .lane_mask_i (merge_mask),
    .merged_o    (merged_word)
  );

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-level reference memory model, response
// scoreboard with latency check, per-cycle memory-port invariants, and
// directed vectors with hand-computed literals.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0, req_byte = 1'b0;
  logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
  logic        req_ready, rsp_valid, rsp_err, mem_enable, mem_wr;
  logic [15:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;

  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];

  int checks = 0, failures = 0, cyc = 0;

  logic [15:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];
  int          acc_q[$];

  lsu_ctrl #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: combinational read, clocked write.
  assign mem_rdata = mem[mem_addr[15:1]];
  always @(posedge clk) if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_wdata;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (byte granular) ----------------
  function automatic logic [7:0] ref_rd_byte(input logic [15:0] a);
    logic [15:0] w;
    w = ref_mem[a[15:1]];
    return a[0] ? w[7:0] : w[15:8];
  endfunction

  task automatic ref_wr_byte(input logic [15:0] a, input logic [7:0] b);
    if (a[0]) ref_mem[a[15:1]][7:0]  = b;
    else      ref_mem[a[15:1]][15:8] = b;
  endtask

  task automatic model_access(input logic wr, input logic byt, input logic [15:0] addr,
                              input logic [15:0] wdata, output logic [15:0] rd,
                              output logic err, output int lat);
    logic [15:0] a2;
    logic        unal;
    unal = !byt && addr[0];
    a2   = addr + 16'd1;
    rd   = 16'h0;
    err  = 1'b0;
    if (TRAP && unal) begin
      err = 1'b1;
      lat = 1;
    end else if (!wr) begin
      if (byt) rd = {8'h00, ref_rd_byte(addr)};
      else     rd = {ref_rd_byte(addr), ref_rd_byte(a2)};
      lat = unal ? 3 : 2;
    end else begin
      if (byt) ref_wr_byte(addr, wdata[7:0]);
      else begin
        ref_wr_byte(addr, wdata[15:8]);
        ref_wr_byte(a2, wdata[7:0]);
      end
      lat = byt ? 3 : (unal ? 5 : 2);
    end
  endtask

  task automatic preload(input logic [15:0] baddr, input logic [15:0] val);
    mem[baddr[15:1]]     = val;
    ref_mem[baddr[15:1]] = val;
  endtask

  task automatic chk_mem(input string name, input logic [15:0] baddr, input logic [15:0] lit);
    check(name, mem[baddr[15:1]], lit);
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic wr, input logic byt, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic chk_lit, input logic [15:0] lit);
    logic [15:0] rd;
    logic        err;
    int          lat;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_byte = byt; req_addr = addr; req_wdata = wdata;
    #1;
    check("req_ready_idle", {15'h0, req_ready}, 16'h1);
    model_access(wr, byt, addr, wdata, rd, err, lat);
    if (chk_lit) check("model_literal", rd, lit);
    exp_q.push_back(rd);
    exp_err_q.push_back(err);
    exp_lat_q.push_back(lat);
    acc_q.push_back(cyc);
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the DUT must ignore them.
    req_valid = 1'b0;
    req_wr    = 1'($urandom_range(0, 1));
    req_byte  = 1'($urandom_range(0, 1));
    req_addr  = 16'($urandom_range(0, 65535));
    req_wdata = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++; failures++;
      $display("FAIL rsp_timeout: no response for addr %h", addr);
      exp_q.delete(); exp_err_q.delete(); exp_lat_q.delete(); acc_q.delete();
    end
    @(negedge clk);
    check("mem_word_a", mem[addr[15:1]], ref_mem[addr[15:1]]);
    check("mem_word_b", mem[16'(addr + 16'd1) >> 1], ref_mem[16'(addr + 16'd1) >> 1]);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!mem_enable && mem_wr) begin
        failures++;
        $display("FAIL wr_without_enable: mem_wr=%b mem_enable=%b", mem_wr, mem_enable);
      end
      checks++;
      if (mem_addr[0] !== 1'b0) begin
        failures++;
        $display("FAIL mem_addr_lsb: mem_addr=%h required bit0=0", mem_addr);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding");
        end else begin
          check("rsp_rdata", rsp_rdata, exp_q.pop_front());
          check("rsp_err", {15'h0, rsp_err}, {15'h0, exp_err_q.pop_front()});
          check("rsp_latency", 16'(cyc - acc_q.pop_front()), 16'(exp_lat_q.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {15'h0, req_ready}, 16'h1);
    check("rst_rsp_valid", {15'h0, rsp_valid}, 16'h0);
    check("rst_rsp_rdata", rsp_rdata, 16'h0);
    check("rst_rsp_err", {15'h0, rsp_err}, 16'h0);
    check("rst_mem_enable", {15'h0, mem_enable}, 16'h0);
    check("rst_mem_wr", {15'h0, mem_wr}, 16'h0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    rst = 1'b0;

    preload(16'h0010, 16'h1234);
    preload(16'h0012, 16'h5678);
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1234);    // word load
    do_req(1'b1, 1'b1, 16'h0011, 16'h00AB, 1'b1, 16'h0000);    // byte store odd
    chk_mem("byte_store_odd", 16'h0010, 16'h12AB);
    do_req(1'b0, 1'b1, 16'h0010, 16'h0000, 1'b1, 16'h0012);    // byte load even
    do_req(1'b0, 1'b1, 16'h0011, 16'h0000, 1'b1, 16'h00AB);    // byte load odd
    preload(16'h0010, 16'h1234);
    do_req(1'b0, 1'b0, 16'h0011, 16'h0000, 1'b1, TRAP ? 16'h0000 : 16'h3456);
    do_req(1'b1, 1'b0, 16'h0020, 16'hCAFE, 1'b1, 16'h0000);    // word store
    chk_mem("word_store", 16'h0020, 16'hCAFE);
    do_req(1'b1, 1'b1, 16'h0020, 16'h775A, 1'b1, 16'h0000);    // byte store even
    chk_mem("byte_store_even", 16'h0020, 16'h5AFE);
    do_req(1'b0, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h5AFE);

    preload(16'hFFFE, 16'h1111);
    preload(16'h0000, 16'h2222);
    do_req(1'b1, 1'b0, 16'hFFFF, 16'hBEEF, 1'b1, 16'h0000);    // wrapping split store
    chk_mem("wrap_store_hi", 16'hFFFE, TRAP ? 16'h1111 : 16'h11BE);
    chk_mem("wrap_store_lo", 16'h0000, TRAP ? 16'h2222 : 16'hEF22);
    do_req(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, TRAP ? 16'h0000 : 16'hBEEF);

    if (!TRAP) begin
      // Reset during RD1 of the wrapping store.
      preload(16'hFFFE, 16'h1111);
      preload(16'h0000, 16'h2222);
      @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b1; req_byte = 1'b0;
      req_addr = 16'hFFFF; req_wdata = 16'hBEEF;
      @(posedge clk);            // accepted, now RD0
      #1 req_valid = 1'b0;
      @(posedge clk);            // WR0
      @(posedge clk);            // RD1
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_req_ready", {15'h0, req_ready}, 16'h1);
      check("abort_rsp_valid", {15'h0, rsp_valid}, 16'h0);
      check("abort_mem_enable", {15'h0, mem_enable}, 16'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk_mem("abort_first_word", 16'hFFFE, 16'h11BE);
      chk_mem("abort_second_word", 16'h0000, 16'h2222);
      ref_mem[16'h7FFF] = 16'h11BE;
    end

    // A few mixed accesses over a small window, including the wrap edge.
    for (int i = 0; i < 12; i++) begin
      logic [15:0] a;
      a = (i % 4 == 3) ? 16'hFFFF : 16'($urandom_range(16'h0030, 16'h003F));
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
             16'($urandom_range(0, 65535)), 1'b0, 16'h0000);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte-address width of request and memory ports.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have req_valid  input  1  request present; req_ready  output  1  request accepted when both high.
REQ-005 SHALL have req_wr  input  1  store (1) / load (0); req_byte  input  1  byte (1) / word (0) access.
REQ-006 SHALL have req_addr  input  ADDR_WIDTH  byte address; req_wdata  input  16  store data (byte stores use bits [7:0]).
REQ-007 SHALL have rsp_valid  output  1  one-cycle completion pulse; rsp_rdata  output  16  load result; rsp_err  output  1  misalignment error.
REQ-008 SHALL have mem_addr  output  ADDR_WIDTH, mem_enable  output  1, mem_wr  output  1, mem_wdata  output  16, mem_rdata  input  16: the 16-bit, byte-addressed data memory port with combinational read and clocked write.

Function
REQ-009 SHALL be big-endian: byte at even address is mem bits [15:8], odd address is bits [7:0].
REQ-010 SHALL drive mem_addr[0]=0 always; memory word address = byte address with bit 0 cleared.
REQ-011 SHALL use FSM states IDLE, RD0, WR0, RD1, WR1, DONE; req_ready=1 only in IDLE.
REQ-012 SHALL assert mem_enable only in RD0/RD1/WR0/WR1; mem_wr=1 only in WR0/WR1; never read and write in the same cycle.
REQ-013 SHALL capture mem_rdata at the end of each RD state.
REQ-014 Aligned word load: IDLE->RD0->DONE; rsp_valid two cycles after acceptance.
REQ-015 Byte load: IDLE->RD0->DONE; selected byte zero-extended into rsp_rdata.
REQ-016 Aligned word store: IDLE->WR0->DONE, mem_wdata=req_wdata.
REQ-017 Byte store (read-modify-write): IDLE->RD0->WR0->DONE; only the addressed byte is replaced.
REQ-018 Unaligned word load: IDLE->RD0->RD1->DONE; rsp_rdata = {low byte of word A, high byte of word A+2}.
REQ-019 Unaligned word store: IDLE->RD0->WR0->RD1->WR1->DONE; req_wdata[15:8] to odd byte of word A, [7:0] to even byte of word A+2.
REQ-020 Second-word address SHALL wrap modulo 2**ADDR_WIDTH (addr 0xFFFF touches words 0xFFFE and 0x0000).
REQ-021 DONE SHALL last one cycle with rsp_valid=1, then go to IDLE; stores return rsp_rdata=0.
REQ-022 Request fields SHALL be latched at acceptance; input changes afterwards have no effect.
REQ-023 rsp_err SHALL be 0 except as stated under Configuration.

Reset
REQ-024 On rst: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_enable=0, mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-025 rst mid-operation SHALL abort immediately; writes already performed remain, pending second-word writes are never issued, no rsp_valid pulse.

Configuration
REQ-026 With LSU_MISALIGN_TRAP_EN defined: unaligned word access SHALL perform no memory cycles, go IDLE->DONE, assert rsp_err=1 with rsp_rdata=0.
REQ-027 Without LSU_MISALIGN_TRAP_EN: unaligned word accesses split per REQ-018/019; rsp_err tied 0.

Structure
REQ-028 Package lsu_pkg SHALL hold the FSM state enum and byte-lane select constants.
REQ-029 Sub-module lsu_byte_merge (combinational: old word, new byte(s), lane mask -> merged word) SHALL be used for RMW data.

Verification
REQ-030 Memory preloaded 0x1234 at 0x0010; word load 0x0010 -> rsp_rdata=0x1234 two cycles after acceptance, rsp_err=0.
REQ-031 Byte store 0xAB to 0x0011 over 0x1234 -> memory word 0x0010 = 0x12AB; byte load 0x0010 -> 0x0012.
REQ-032 Words 0x0010=0x1234, 0x0012=0x5678; word load 0x0011 -> 0x3456 (split) or rsp_err=1 with LSU_MISALIGN_TRAP_EN.
REQ-033 Word store 0xBEEF to 0xFFFF with words 0xFFFE=0x1111, 0x0000=0x2222 -> 0xFFFE=0x11BE, 0x0000=0xEF22.
REQ-034 rst asserted in RD1 of REQ-033 store -> word 0xFFFE updated, word 0x0000 unchanged, no rsp_valid, req_ready=1 next cycle.
REQ-035 Every cycle: mem_enable=0 implies mem_wr=0, and mem_addr[0]=0.
